// File: rtl/demux1t4_32_stream_pkg.sv
// Shared definitions for the 1-to-4 word stream distributor.
// Channel select encodings, default widths and the select decoder.
package demux1t4_32_stream_pkg;

    localparam int W_DEF     = 32;
    localparam int CNT_W_DEF = 16;
    localparam int NCH       = 4;

    typedef enum logic [1:0] {
        CH0 = 2'b00,
        CH1 = 2'b01,
        CH2 = 2'b10,
        CH3 = 2'b11
    } ch_e;

    function automatic logic [NCH-1:0] ch_onehot(
        input logic [1:0] s
    );
        logic [NCH-1:0] oh;
        oh = '0;
        unique case (ch_e'(s))
            CH0: oh = 4'b0001;
            CH1: oh = 4'b0010;
            CH2: oh = 4'b0100;
            CH3: oh = 4'b1000;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux1t4_32_stream_slot.sv
// One output channel: word register, valid flag and delivered-word counter.
// A drain and a load on the same edge replace the word with no bubble.
module demux_slot #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     din,
    output logic             valid,
    input  logic             ready,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] cnt
);

    logic             valid_q;
    logic             valid_d;
    logic [W-1:0]     data_q;
    logic [W-1:0]     data_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             drain;

    assign drain = valid_q & ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (drain) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        // A load wins over the drain of the previous word.
        if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/demux1t4_32_stream.sv
// Registered 1-to-4 stream distributor for 32-bit words.
// Each channel buffers one word, so a stalled consumer only blocks its own channel.
module demux1t4_32_stream
    import demux1t4_32_stream_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     in_data,
    input  logic [1:0]       in_s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     o0,
    output logic [W-1:0]     o1,
    output logic [W-1:0]     o2,
    output logic [W-1:0]     o3,
    output logic [3:0]       o_valid,
    input  logic [3:0]       o_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    logic [NCH-1:0] sel_oh;
    logic [NCH-1:0] load;
    logic [W-1:0]   dout [NCH];
    logic [CNT_W-1:0] cnt [NCH];
    logic           accept;

    assign sel_oh   = ch_onehot(in_s);
    assign in_ready = ~o_valid[in_s] | o_ready[in_s];
    assign accept   = in_valid & in_ready;
    assign load     = accept ? sel_oh : '0;

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .W     (W),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .din   (in_data),
            .valid (o_valid[k]),
            .ready (o_ready[k]),
            .dout  (dout[k]),
            .cnt   (cnt[k])
        );
    end

    assign o0   = dout[0];
    assign o1   = dout[1];
    assign o2   = dout[2];
    assign o3   = dout[3];
    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];

endmodule

// File: tb/tb_demux1t4_32_stream.sv
// Bench for demux1t4_32_stream: directed scenarios plus random traffic,
// checked by a queue-based per-channel scoreboard on the falling edge.
module tb_demux1t4_32_stream;

    localparam int W     = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [W-1:0]     in_data;
    logic [1:0]       in_s;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     o0, o1, o2, o3;
    logic [3:0]       o_valid;
    logic [3:0]       o_ready;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

    demux1t4_32_stream #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_s     (in_s),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .o0       (o0),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .cnt2     (cnt2),
        .cnt3     (cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    logic [W-1:0] oa [4];
    logic [CNT_W-1:0] ca [4];
    assign oa[0] = o0;
    assign oa[1] = o1;
    assign oa[2] = o2;
    assign oa[3] = o3;
    assign ca[0] = cnt0;
    assign ca[1] = cnt1;
    assign ca[2] = cnt2;
    assign ca[3] = cnt3;

    // Scoreboard: words owed to each consumer, and delivered counts mod 2^CNT_W.
    logic [W-1:0] eq [4][$];
    int mcnt [4];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                eq[k].delete();
                mcnt[k] = 0;
            end
            chk("rst_o_valid", 32'(o_valid), 32'h0);
            chk("rst_in_ready", 32'(in_ready), 32'h1);
            chk("rst_cnt", 32'({cnt0, cnt1, cnt2, cnt3}), 32'h0);
            chk("rst_o_or", o0 | o1 | o2 | o3, 32'h0);
        end else begin
            logic rdy;
            rdy = (eq[in_s].size() == 0) || o_ready[in_s];
            chk("in_ready", 32'(in_ready), 32'(rdy));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("o_valid%0d", k), 32'(o_valid[k]),
                    32'(eq[k].size() != 0));
                chk($sformatf("cnt%0d", k), 32'(ca[k]), 32'(mcnt[k]));
                if (eq[k].size() != 0) begin
                    chk($sformatf("o%0d", k), oa[k], eq[k][0]);
                    if (o_ready[k]) begin
                        void'(eq[k].pop_front());
                        mcnt[k] = (mcnt[k] + 1) % (1 << CNT_W);
                    end
                end
            end
            if (in_valid && rdy) eq[in_s].push_back(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_s     = s;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_s     = 2'b01;
        in_data  = 32'hCAFE0001;
        o_ready  = 4'b0000;
        step();
        step();
        step();
        chk("t1_o_valid", 32'(o_valid), 32'h0);
        chk("t1_o1", o1, 32'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();

        send(2'b10, 32'hDEADBEEF);
        chk("t2_o2", o2, 32'hDEADBEEF);
        chk("t2_o_valid", 32'(o_valid), 32'h4);
        in_s = 2'b10;
        #1 chk("t2_rdy_s2", 32'(in_ready), 32'h0);
        in_s = 2'b00;
        #1 chk("t2_rdy_s0", 32'(in_ready), 32'h1);

        o_ready = 4'b0100;
        step();
        o_ready = 4'b0000;
        send(2'b01, 32'hAAAA5555);
        send(2'b11, 32'h11111111);
        chk("t3_o_valid", 32'(o_valid), 32'hA);
        chk("t3_o1", o1, 32'hAAAA5555);
        chk("t3_o3", o3, 32'h11111111);
        o_ready = 4'b1111;
        step();
        chk("t3_drained", 32'(o_valid), 32'h0);

        o_ready = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_s     = 2'b00;
            in_data  = 32'(i);
            #1 chk("t4_no_bubble", 32'(in_ready), 32'h1);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("t4_cnt0", 32'(cnt0), 32'h8);

        o_ready = 4'b0000;
        send(2'b11, 32'hA0A0A0A0);
        o_ready = 4'b1000;
        send(2'b11, 32'hB0B0B0B0);
        chk("t5_o3", o3, 32'hB0B0B0B0);
        chk("t5_v3", 32'(o_valid[3]), 32'h1);
        chk("t5_cnt3", 32'(cnt3), 32'h2);
        o_ready = 4'b1111;
        step();

        do_reset();
        o_ready = 4'b0010;
        for (int i = 0; i < 17; i++) send(2'b01, 32'h100 + 32'(i));
        step();
        chk("t6_wrap_cnt1", 32'(cnt1), 32'h1);

        o_ready = 4'b0000;
        send(2'b01, 32'h5A5A5A5A);
        in_valid = 1'b1;
        in_data  = 32'h77777777;
        #2 rst_n = 1'b0;
        #1 chk("t6_async_valid", 32'(o_valid), 32'h0);
        chk("t6_async_o1", o1, 32'h0);
        chk("t6_async_cnt1", 32'(cnt1), 32'h0);
        step();
        step();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();

        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_s     = 2'($urandom_range(0, 3));
            in_data  = $urandom;
            o_ready  = 4'($urandom_range(0, 15));
            step();
        end
        in_valid = 1'b0;
        o_ready  = 4'b1111;
        step();
        step();
        chk("final_empty", 32'(o_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
